// File: rtl/vga_pkg.sv
// Shared pattern-mode encoding and default 640x480@60 timing for the VGA path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_WHITE = 2'd0,
        MODE_RECT  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

endpackage

// File: rtl/vga_timing_pattern_gen_if.sv
// Registered video output bundle: syncs, data enable, colour and pixel coordinates.
// Latency: n/a (wires only).
// Backpressure: none; the sink must accept every pixel-enable tick.
interface vga_timing_pattern_gen_if #(
    parameter int COLOR_W = 4,
    parameter int CNT_W   = 11
);
    logic               VGA_HS;
    logic               VGA_VS;
    logic               VGA_DE;
    logic [COLOR_W-1:0] VGA_R;
    logic [COLOR_W-1:0] VGA_G;
    logic [COLOR_W-1:0] VGA_B;
    logic [CNT_W-1:0]   CUR_X;
    logic [CNT_W-1:0]   CUR_Y;
    logic               FRAME_START;
    logic [15:0]        FRAME_CNT;

    modport master (
        output VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B,
               CUR_X, CUR_Y, FRAME_START, FRAME_CNT
    );

    modport slave (
        input  VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B,
               CUR_X, CUR_Y, FRAME_START, FRAME_CNT
    );
endinterface

// File: rtl/vga_pattern_rom.sv
// Test-pattern colour decode from pattern mode and pixel (x, y).
// Latency: combinational.
// Backpressure: none.
module vga_pattern_rom
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int COLOR_W  = 4,
    parameter int CNT_W    = 11,
    parameter int RECT_X0  = 160,
    parameter int RECT_Y0  = 120,
    parameter int RECT_X1  = 480,
    parameter int RECT_Y1  = 360,
    parameter int CHK_LOG2 = 5
) (
    input  mode_e              mode,
    input  logic [CNT_W-1:0]   x,
    input  logic [CNT_W-1:0]   y,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
    localparam logic [CNT_W-1:0] RX0   = CNT_W'(RECT_X0);
    localparam logic [CNT_W-1:0] RY0   = CNT_W'(RECT_Y0);
    localparam logic [CNT_W-1:0] RX1   = CNT_W'(RECT_X1);
    localparam logic [CNT_W-1:0] RY1   = CNT_W'(RECT_Y1);

    logic [CNT_W-1:0] bar_raw;
    logic [2:0]       bar;
    logic             in_rect;
    logic             chk;

    always_comb begin
        bar_raw = x / BAR_W;
        // Leftover columns when H_ACTIVE is not a multiple of 8 stay in the last bar
        bar     = (bar_raw > CNT_W'(7)) ? 3'd7 : bar_raw[2:0];
        in_rect = (x >= RX0) && (x < RX1) && (y >= RY0) && (y < RY1);
        chk     = x[CHK_LOG2] ^ y[CHK_LOG2];
        r = '0;
        g = '0;
        b = '0;
        case (mode)
            MODE_WHITE: begin
                r = '1;
                g = '1;
                b = '1;
            end
            MODE_RECT: begin
                if (in_rect) r = '1;
            end
            MODE_BARS: begin
                r = {COLOR_W{bar[2]}};
                g = {COLOR_W{bar[1]}};
                b = {COLOR_W{bar[0]}};
            end
            default: begin
                if (chk) begin
                    r = '1;
                    g = '1;
                    b = '1;
                end
            end
        endcase
    end

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with test-pattern source; VGA_SCROLL_EN adds per-frame horizontal scroll.
// Latency: one PIX_EN tick from counter value to all (mutually aligned) outputs.
// Backpressure: none; PIX_EN=0 freezes every register including outputs.
module vga_timing_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int CNT_W    = 11,
    parameter int RECT_X0  = 160,
    parameter int RECT_Y0  = 120,
    parameter int RECT_X1  = 480,
    parameter int RECT_Y1  = 360,
    parameter int CHK_LOG2 = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PIX_EN,
    input  logic [1:0] MODE,
    vga_timing_pattern_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((2**CNT_W) <= H_TOTAL || (2**CNT_W) <= V_TOTAL || H_ACTIVE < 8 ||
        CHK_LOG2 >= CNT_W || COLOR_W < 1) begin : g_param_check
        $error("vga_timing_pattern_gen: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HA       = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA       = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]   h_cnt, v_cnt, x_pat;
    mode_e              mode_q, mode_eff;
    logic               started;
    logic               frame_top, h_wrap, v_wrap, active, hs_act, vs_act;
    logic [COLOR_W-1:0] pat_r, pat_g, pat_b;

    logic               hs_q, vs_q, de_q, fs_q;
    logic [COLOR_W-1:0] r_q, g_q, b_q;
    logic [CNT_W-1:0]   cur_x_q, cur_y_q;
    logic [15:0]        frame_cnt_q;

    always_comb begin
        frame_top = (h_cnt == '0) && (v_cnt == '0);
        h_wrap    = (h_cnt == H_LAST);
        v_wrap    = (v_cnt == V_LAST);
        active    = (h_cnt < HA) && (v_cnt < VA);
        hs_act    = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_act    = (v_cnt >= VS_START) && (v_cnt < VS_END);
        // The first pixel of a frame already uses the newly sampled mode
        mode_eff  = frame_top ? mode_e'(MODE) : mode_q;
    end

`ifdef VGA_SCROLL_EN
    logic [CNT_W-1:0] offset_q, offset_eff;
    logic [CNT_W:0]   x_sum;

    always_comb begin
        offset_eff = offset_q;
        if (frame_top && started)
            offset_eff = (offset_q == HA - CNT_W'(1)) ? '0 : offset_q + CNT_W'(1);
        x_sum = {1'b0, h_cnt} + {1'b0, offset_eff};
        x_pat = (x_sum >= {1'b0, HA}) ? CNT_W'(x_sum - {1'b0, HA}) : x_sum[CNT_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)        offset_q <= '0;
        else if (PIX_EN) offset_q <= offset_eff;
    end
`else
    assign x_pat = h_cnt;
`endif

    vga_pattern_rom #(
        .H_ACTIVE (H_ACTIVE),
        .COLOR_W  (COLOR_W),
        .CNT_W    (CNT_W),
        .RECT_X0  (RECT_X0),
        .RECT_Y0  (RECT_Y0),
        .RECT_X1  (RECT_X1),
        .RECT_Y1  (RECT_Y1),
        .CHK_LOG2 (CHK_LOG2)
    ) u_rom (
        .mode (mode_eff),
        .x    (x_pat),
        .y    (v_cnt),
        .r    (pat_r),
        .g    (pat_g),
        .b    (pat_b)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            mode_q      <= MODE_WHITE;
            started     <= 1'b0;
            frame_cnt_q <= '0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
        end else if (PIX_EN) begin
            h_cnt   <= h_wrap ? '0 : h_cnt + CNT_W'(1);
            if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
            started <= 1'b1;
            if (frame_top) begin
                mode_q <= mode_eff;
                // The frame that starts right after reset is frame 0, not a completed one
                if (started) frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            hs_q    <= hs_act ? HS_POL : ~HS_POL;
            vs_q    <= vs_act ? VS_POL : ~VS_POL;
            de_q    <= active;
            fs_q    <= frame_top;
            r_q     <= active ? pat_r : '0;
            g_q     <= active ? pat_g : '0;
            b_q     <= active ? pat_b : '0;
            cur_x_q <= h_cnt;
            cur_y_q <= v_cnt;
        end
    end

    assign vid.VGA_HS      = hs_q;
    assign vid.VGA_VS      = vs_q;
    assign vid.VGA_DE      = de_q;
    assign vid.VGA_R       = r_q;
    assign vid.VGA_G       = g_q;
    assign vid.VGA_B       = b_q;
    assign vid.CUR_X       = cur_x_q;
    assign vid.CUR_Y       = cur_y_q;
    assign vid.FRAME_START = fs_q;
    assign vid.FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench: directed checks on the default 640x480 instance plus a randomized small-config
// instance compared every clock against a frame/pixel-index reference model.
module tb_vga_timing_pattern_gen;

    localparam int S_HA = 8, S_HFP = 2, S_HSW = 2, S_HBP = 2;
    localparam int S_VA = 4, S_VFP = 1, S_VSW = 1, S_VBP = 1;
    localparam int S_HT = S_HA + S_HFP + S_HSW + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VSW + S_VBP;
    localparam int S_FT = S_HT * S_VT;
    localparam bit S_HS_POL = 1'b1;
    localparam bit S_VS_POL = 1'b0;
    localparam int S_RX0 = 2, S_RY0 = 1, S_RX1 = 6, S_RY1 = 3, S_CHK = 1;

    logic       clk = 1'b0;
    logic       d_rst = 1'b1, d_en = 1'b0;
    logic       s_rst = 1'b1, s_en = 1'b0;
    logic [1:0] d_mode = 2'd2, s_mode = 2'd0;
    int         checks = 0;
    int         failures = 0;
    int         s_n = 0;
    int         s_fmode = 0;

    always #5 clk = ~clk;

    vga_timing_pattern_gen_if #(.COLOR_W(4), .CNT_W(11)) d_if ();
    vga_timing_pattern_gen_if #(.COLOR_W(1), .CNT_W(4))  s_if ();

    vga_timing_pattern_gen u_dflt (
        .CLK(clk), .RST(d_rst), .PIX_EN(d_en), .MODE(d_mode), .vid(d_if)
    );

    vga_timing_pattern_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
        .HS_POL(S_HS_POL), .VS_POL(S_VS_POL), .COLOR_W(1), .CNT_W(4),
        .RECT_X0(S_RX0), .RECT_Y0(S_RY0), .RECT_X1(S_RX1), .RECT_Y1(S_RY1),
        .CHK_LOG2(S_CHK)
    ) u_small (
        .CLK(clk), .RST(s_rst), .PIX_EN(s_en), .MODE(s_mode), .vid(s_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Channel on/off flags {r,g,b}; every pattern drives a channel either full or zero
    function automatic logic [2:0] pat_ref(int mode, int x, int y, int ha,
                                           int x0, int y0, int x1, int y1, int cl);
        int b;
        case (mode)
            0: return 3'b111;
            1: return (x >= x0 && x < x1 && y >= y0 && y < y1) ? 3'b100 : 3'b000;
            2: begin
                b = x / (ha / 8);
                if (b > 7) b = 7;
                return 3'(b);
            end
            default: return ((((x >> cl) ^ (y >> cl)) & 1) != 0) ? 3'b111 : 3'b000;
        endcase
    endfunction

    // n = enabled edges since reset; the outputs then show pixel index n-1
    function automatic logic [63:0] s_exp(int n, int fm);
        int p, h, v, f, x;
        logic act, hs, vs, fs;
        logic [2:0] c;
        if (n == 0)
            return {33'b0, !S_HS_POL, !S_VS_POL, 1'b0, 3'b000, 8'h00, 1'b0, 16'h0000};
        p   = n - 1;
        h   = p % S_HT;
        v   = (p / S_HT) % S_VT;
        f   = p / S_FT;
        act = (h < S_HA) && (v < S_VA);
        hs  = (h >= S_HA + S_HFP && h < S_HA + S_HFP + S_HSW) ? S_HS_POL : !S_HS_POL;
        vs  = (v >= S_VA + S_VFP && v < S_VA + S_VFP + S_VSW) ? S_VS_POL : !S_VS_POL;
        fs  = (p % S_FT == 0);
`ifdef VGA_SCROLL_EN
        x = (h + f % S_HA) % S_HA;
`else
        x = h;
`endif
        c = act ? pat_ref(fm, x, v, S_HA, S_RX0, S_RY0, S_RX1, S_RY1, S_CHK) : 3'b000;
        return {33'b0, hs, vs, act, c, 4'(h), 4'(v), fs, 16'(f)};
    endfunction

    function automatic logic [63:0] s_obs();
        return {33'b0, s_if.VGA_HS, s_if.VGA_VS, s_if.VGA_DE, s_if.VGA_R, s_if.VGA_G,
                s_if.VGA_B, s_if.CUR_X, s_if.CUR_Y, s_if.FRAME_START, s_if.FRAME_CNT};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fall1, rise1, fall2;
        logic hs_prev;

        #2;
        d_rst = 1'b0;
        s_rst = 1'b0;
        repeat (3) @(negedge clk);

        // Default instance: reset values
        chk("d_rst_hs", d_if.VGA_HS, 1);
        chk("d_rst_vs", d_if.VGA_VS, 1);
        chk("d_rst_de", d_if.VGA_DE, 0);
        chk("d_rst_rgb", {d_if.VGA_R, d_if.VGA_G, d_if.VGA_B}, 0);
        chk("d_rst_xy", {d_if.CUR_X, d_if.CUR_Y}, 0);
        chk("d_rst_fs", d_if.FRAME_START, 0);
        chk("d_rst_fc", d_if.FRAME_CNT, 0);

        // Continuous PIX_EN, colour bars from the first frame
        d_rst = 1'b1;
        d_en  = 1'b1;
        fall1 = -1; rise1 = -1; fall2 = -1; hs_prev = 1'b1;
        for (int t = 1; t <= 1700; t++) begin
            @(posedge clk); #1;
            if (t == 1) begin
                chk("d_fs_first", d_if.FRAME_START, 1);
                chk("d_xy_first", {d_if.CUR_X, d_if.CUR_Y}, 0);
                chk("d_de_first", d_if.VGA_DE, 1);
                chk("d_bar_0", {d_if.VGA_R, d_if.VGA_G, d_if.VGA_B}, 12'h000);
            end
            if (t == 2) chk("d_fs_second", d_if.FRAME_START, 0);
            if (t == 80) begin
                chk("d_x_79", d_if.CUR_X, 79);
                chk("d_bar_79", {d_if.VGA_R, d_if.VGA_G, d_if.VGA_B}, 12'h000);
            end
            if (t == 81) chk("d_bar_80", {d_if.VGA_R, d_if.VGA_G, d_if.VGA_B}, 12'h00F);
            if (t == 640) chk("d_bar_639", {d_if.VGA_R, d_if.VGA_G, d_if.VGA_B}, 12'hFFF);
            if (t == 641) chk("d_blank_640", {d_if.VGA_DE, d_if.VGA_R, d_if.VGA_G, d_if.VGA_B}, 0);
            if (hs_prev && !d_if.VGA_HS) begin
                if (fall1 < 0) fall1 = t;
                else if (fall2 < 0) fall2 = t;
            end
            if (!hs_prev && d_if.VGA_HS && rise1 < 0) rise1 = t;
            hs_prev = d_if.VGA_HS;
        end
        chk("d_hs_fall", fall1, 657);
        chk("d_hs_low", rise1 - fall1, 96);
        chk("d_hs_period", fall2 - fall1, 800);

        // Asynchronous reset in the middle of a line
        @(negedge clk);
        d_rst = 1'b0;
        #1;
        chk("d_mid_rst", {d_if.VGA_HS, d_if.VGA_VS, d_if.VGA_DE, d_if.CUR_X, d_if.CUR_Y,
                          d_if.FRAME_CNT}, {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 16'd0});
        @(negedge clk);
        d_rst = 1'b1;

        // PIX_EN toggling every cycle halves the pixel rate
        fall1 = -1; fall2 = -1; hs_prev = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            d_en = (c % 2 == 1);
            @(posedge clk); #1;
            if (c == 1) chk("d_tog_fs", d_if.FRAME_START, 1);
            if (c == 2) chk("d_tog_hold_x", d_if.CUR_X, 0);
            if (hs_prev && !d_if.VGA_HS) begin
                if (fall1 < 0) fall1 = c;
                else if (fall2 < 0) fall2 = c;
            end
            hs_prev = d_if.VGA_HS;
            @(negedge clk);
        end
        d_en = 1'b0;
        chk("d_tog_fall", fall1, 1313);
        chk("d_tog_period", fall2 - fall1, 1600);

        // Small instance: random PIX_EN and MODE against the reference model
        chk("s_px_rst", s_obs(), s_exp(0, 0));
        @(negedge clk);
        s_rst = 1'b1;
        s_n = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (c == 3000) begin
                s_rst = 1'b0;
                #1;
                s_n = 0;
                chk("s_px_midrst", s_obs(), s_exp(0, 0));
                @(negedge clk);
                s_rst = 1'b1;
            end
            s_en = ($urandom_range(3) != 0);
            if ($urandom_range(199) == 0) s_mode = 2'($urandom_range(3));
            if (s_en) begin
                if (s_n % S_FT == 0) s_fmode = int'(s_mode);
                s_n++;
            end
            @(posedge clk); #1;
            chk("s_px", s_obs(), s_exp(s_n, s_fmode));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
Parametrised VGA timing generator with a built-in test-pattern source. It produces registered HS/VS, data-enable, pixel coordinates and RGB for any timing set and colour depth. Pixel rate is set by a clock-enable input, so the block runs on the system clock with no derived clock. It sits at the top of the display path and can be replaced later by a framebuffer reader that uses the same coordinate outputs.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of VGA_HS (0 = active-low)
VS_POL, 0, active level of VGA_VS
COLOR_W, 4, bits per colour channel
CNT_W, 11, width of coordinate counters; must satisfy 2^CNT_W > max(H_TOTAL, V_TOTAL)
RECT_X0/RECT_Y0/RECT_X1/RECT_Y1, 160/120/480/360, rectangle bounds (X0 and Y0 inclusive, X1 and Y1 exclusive)
CHK_LOG2, 5, checker square size is 2^CHK_LOG2 pixels

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
PIX_EN  in  1  pixel-rate enable; all state advances only when high
MODE  in  2  pattern select (0 white, 1 rectangle, 2 colour bars, 3 checker)
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
VGA_DE  out  1  active-video flag
VGA_R/VGA_G/VGA_B  out  COLOR_W each  colour channels
CUR_X/CUR_Y  out  CNT_W each  coordinates of the pixel currently on the RGB outputs
FRAME_START  out  1  one-PIX_EN-tick pulse aligned with pixel (0,0) on the outputs
FRAME_CNT  out  16  completed-frame count, wraps at 0xFFFF to 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the vertical parameters.
- Reset (RST=0, asynchronous) sets:
  - h_cnt=0, v_cnt=0, mode_q=0 (white), FRAME_CNT=0
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL
  - VGA_DE=0, RGB=0, CUR_X=0, CUR_Y=0, FRAME_START=0
- Counters change only on a CLK edge with PIX_EN=1:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - On the h_cnt wrap, v_cnt counts 0..V_TOTAL-1, then wraps to 0.
- Decode is combinational from (h_cnt, v_cnt):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs_act = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_act = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - VS is driven from whole lines, with no half-line offset.
- Output stage: all outputs are registered on PIX_EN. Latency is exactly one PIX_EN tick from counter value to outputs. HS, VS, DE, RGB, CUR_X and CUR_Y stay mutually aligned.
- PIX_EN=0 holds every register, including outputs.
- RGB is 0 whenever DE=0. Every active pixel, including column 0, is driven by the pattern.
- Mode latch:
  - mode_q samples MODE only on the tick where h_cnt=0 and v_cnt=0.
  - A MODE change mid-frame takes effect from the next frame's first pixel. There is no tearing.
- FRAME_START and FRAME_CNT: on the tick where counters read (0,0), the registered FRAME_START goes to 1. FRAME_CNT increments on that same tick, except on the first frame after reset, where it stays 0.
- Patterns, with x=h_cnt and y=v_cnt, full = all-ones COLOR_W:
  - 0 (white): R=G=B=full.
  - 1 (rectangle): inside the bounds R=full, G=B=0; outside, all channels 0.
  - 2 (colour bars): BAR_W = H_ACTIVE/8 (integer division), b = min(x/BAR_W, 7). R=b[2], G=b[1], B=b[0], each replicated to full or 0. Bar 0 is black and bar 7 is white.
  - 3 (checker): white if x[CHK_LOG2]^y[CHK_LOG2], else black.
- Width rule: all comparisons use CNT_W-bit unsigned values. The parameter limits are checked at elaboration with a generate-time error.

Optional Feature:
- Macro VGA_SCROLL_EN.
- When defined:
  - A scroll offset register (CNT_W bits, reset 0) increments by 1 at each frame start and wraps from H_ACTIVE-1 to 0.
  - The pattern x coordinate becomes (h_cnt+offset) mod H_ACTIVE, which scrolls bars, checker and rectangle horizontally.
  - CUR_X still reports the unscrolled h_cnt.
- When undefined: offset logic is absent and x=h_cnt.

Decomposition:
- Shared package vga_pkg holds:
  - the pattern-mode enum (MODE_WHITE=0, MODE_RECT=1, MODE_BARS=2, MODE_CHECK=3)
  - the 640x480@60 timing constants used as defaults
- One sub-module, vga_pattern_rom, is the combinational mode + (x, y) -> RGB decode. The top keeps the counters, sync decode, mode latch and output registers.

Test Plan:
- Defaults, PIX_EN=1 constantly:
  - VGA_HS period is 800 ticks, low for 96 ticks starting at output tick 657 (h_cnt 656 + 1 latency).
  - VGA_VS is low for 2 lines of 525.
  - VGA_DE is high for 307200 ticks per frame.
- MODE=2 at defaults: CUR_X=79 gives RGB=0/0/0 and CUR_X=80 gives R=0,G=0,B=0xF. CUR_X=639 gives RGB=F/F/F.
- MODE switched 0->1 at line 200 of frame N: frame N stays all white. In frame N+1, CUR_X=160/CUR_Y=120 gives R=0xF,G=0,B=0, and CUR_X=480 gives black.
- PIX_EN toggling 1/0 every cycle: outputs change only on enabled edges, and the HS period measures 1600 CLK cycles.
- RST pulsed low mid-line 300: outputs immediately go to the reset values (HS/VS inactive, DE=0, FRAME_CNT=0). After release, the first FRAME_START comes one tick after the first enabled edge.
- Small config (H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, COLOR_W=1), with VGA_SCROLL_EN defined and MODE=3, CHK_LOG2=1: over several frames FRAME_CNT increments and the checker phase shifts by 1 pixel per frame. The offset wraps from 7 to 0.
